// File: rtl/sdp_sram_pipelined.sv
// sdp_sram_pipelined
// Simple dual-port, single-clock SRAM with byte-lane write enables, a
// registered read path of 1 or 2 cycles, a selectable read-during-write
// policy and a clear sequencer that zeroes the array after reset or on a
// clear pulse. The array itself is never touched by rst_n; only the control
// state and the read pipeline are reset.
module sdp_sram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    output logic                                busy,
    input  logic                                write_enable,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    write_byte_enable,
    input  logic [ADDR_WIDTH-1:0]               write_address,
    input  logic [DATA_WIDTH-1:0]               write_data,
    input  logic                                read_enable,
    input  logic [ADDR_WIDTH-1:0]               read_address,
    output logic [DATA_WIDTH-1:0]               read_data,
    output logic                                read_valid
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Clear sequencer state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_busy;

    // Storage; no reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    // Read pipeline stage 1
    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_data;

    // Control decode
    logic                    w_clearing;
    logic                    w_blocked;
    logic                    w_user_wr;
    logic                    w_user_rd;

    // Muxed memory write port (clear sequencer has priority)
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [NB-1:0]           w_mem_mask;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    // Read word as seen by stage 1 after the read-during-write merge
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic                    w_same_addr;
    logic [DATA_WIDTH-1:0]   w_rd_merged;

    // User traffic is dropped while the sequencer runs and in the cycle a
    // clear request arrives, so the clear never races a user write.
    assign w_clearing = (r_state == ST_CLEAR);
    assign w_blocked  = w_clearing | clear;
    assign w_user_wr  = write_enable & ~w_blocked;
    assign w_user_rd  = read_enable & ~w_blocked;

    assign w_mem_we    = w_clearing | w_user_wr;
    assign w_mem_addr  = w_clearing ? r_ptr : write_address;
    assign w_mem_mask  = w_clearing ? {NB{1'b1}} : write_byte_enable;
    assign w_mem_wdata = w_clearing ? '0 : write_data;

    assign busy = r_busy;

    // Clear FSM: walks r_ptr over every word, then hands over to normal use.
    // A clear pulse seen while already clearing is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_busy  <= (CLEAR_ON_RESET != 0);
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + ADDR_WIDTH'(1);
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port with per-lane enables; an all-zero mask writes nothing.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_mem_mask[i]) begin
                    r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        w_mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read-during-write: in new-data mode, lanes being written to the same
    // address this cycle are forwarded from the write bus; old-data mode
    // just returns the stored word, which the non-blocking write has not
    // yet updated.
    assign w_rd_word   = r_mem[read_address];
    assign w_same_addr = w_user_wr & (write_address == read_address);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_rdw_lane
            if (RDW_MODE == 1) begin : g_new
                assign w_rd_merged[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                    (w_same_addr && write_byte_enable[gi])
                        ? write_data[gi*BYTE_WIDTH +: BYTE_WIDTH]
                        : w_rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin : g_old
                assign w_rd_merged[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                    w_rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    endgenerate

    // Stage 1 captures the addressed word; it holds when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_user_rd;
            if (w_user_rd) begin
                r_s1_data <= w_rd_merged;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;

            // Output register: moves a completed stage-1 read out one cycle
            // later; the value is frozen at stage 1 so later writes cannot
            // alter it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign read_data  = r_s2_data;
            assign read_valid = r_s2_valid;
        end else begin : g_lat1
            assign read_data  = r_s1_data;
            assign read_valid = r_s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_sram_pipelined.sv
// tb_sdp_sram_pipelined
// Directed bench for sdp_sram_pipelined. Two instances share one stimulus:
// u_a uses the defaults (1-cycle latency, old-data read-during-write) and
// u_b uses 2-cycle latency with new-data read-during-write. Both hold the
// same array contents, so expected data differ only in timing and RDW.
module tb_sdp_sram_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        we;
    logic [3:0]  wbe;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  raddr;

    logic        a_busy, b_busy;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_sram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(a_busy),
        .write_enable(we), .write_byte_enable(wbe), .write_address(waddr),
        .write_data(wdata), .read_enable(re), .read_address(raddr),
        .read_data(a_data), .read_valid(a_valid)
    );

    sdp_sram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(b_busy),
        .write_enable(we), .write_byte_enable(wbe), .write_address(waddr),
        .write_data(wdata), .read_enable(re), .read_address(raddr),
        .read_data(b_data), .read_valid(b_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; waddr = a; wdata = d; wbe = m;
        tick();
        we = 1'b0; wbe = 4'h0;
    endtask

    // One read: latency-1 result after the first edge, latency-2 after the second.
    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0;
        chk($sformatf("a_valid@%0d", a), {31'd0, a_valid}, 32'd1);
        chk($sformatf("a_data@%0d", a), a_data, exp);
        chk($sformatf("b_early@%0d", a), {31'd0, b_valid}, 32'd0);
        tick();
        chk($sformatf("a_drop@%0d", a), {31'd0, a_valid}, 32'd0);
        chk($sformatf("b_valid@%0d", a), {31'd0, b_valid}, 32'd1);
        chk($sformatf("b_data@%0d", a), b_data, exp);
        $display("read addr %0d exp %h a %h b %h", a, exp, a_data, b_data);
    endtask

    // Counts edges until busy drops; the bound keeps a stuck FSM from hanging.
    task automatic count_busy(input string tag, input int clear_at);
        int cnt;
        cnt = 0;
        while (a_busy && cnt < 40) begin
            clear = (cnt == clear_at);
            tick();
            cnt++;
            chk({tag, "_rd_blocked"}, {31'd0, a_valid}, 32'd0);
        end
        clear = 1'b0;
        chk({tag, "_busy_cycles"}, cnt, 32'd16);
        chk({tag, "_b_busy_low"}, {31'd0, b_busy}, 32'd0);
        $display("%s busy cycles %0d", tag, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; we = 1'b0; wbe = 4'h0; waddr = 4'h0;
        wdata = 32'h0; re = 1'b0; raddr = 4'h0;

        // Reset state
        tick(); tick();
        chk("rst_a_busy", {31'd0, a_busy}, 32'd1);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_b_data", b_data, 32'd0);
        $display("reset state busy %b valid %b data %h", a_busy, a_valid, a_data);

        // Reset-clear: write and read to addr 3 held throughout busy are dropped
        rst_n = 1'b1;
        we = 1'b1; waddr = 4'd3; wdata = 32'h12345678; wbe = 4'hF;
        re = 1'b1; raddr = 4'd3;
        count_busy("rstclr", -1);
        we = 1'b0; wbe = 4'h0; re = 1'b0;
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);

        // Byte enables
        wr(4'd5, 32'hAABBCCDD, 4'hF);
        wr(4'd5, 32'h11223344, 4'b0101);
        rd(4'd5, 32'hAA22CC44);

        // Zero mask is a no-op
        wr(4'd5, 32'hFFFFFFFF, 4'b0000);
        rd(4'd5, 32'hAA22CC44);

        // Read-during-write at addr 7 (holds 0)
        we = 1'b1; waddr = 4'd7; wdata = 32'hDEADBEEF; wbe = 4'b0011;
        re = 1'b1; raddr = 4'd7;
        tick();
        we = 1'b0; wbe = 4'h0; re = 1'b0;
        chk("rdw_a_valid", {31'd0, a_valid}, 32'd1);
        chk("rdw_old", a_data, 32'h00000000);
        tick();
        chk("rdw_b_valid", {31'd0, b_valid}, 32'd1);
        chk("rdw_new", b_data, 32'h0000BEEF);
        $display("rdw a %h b %h", a_data, b_data);
        rd(4'd7, 32'h0000BEEF);

        // Different addresses do not interact
        we = 1'b1; waddr = 4'd8; wdata = 32'h0BADF00D; wbe = 4'hF;
        re = 1'b1; raddr = 4'd7;
        tick();
        we = 1'b0; wbe = 4'h0; re = 1'b0;
        chk("diff_a", a_data, 32'h0000BEEF);
        tick();
        chk("diff_b", b_data, 32'h0000BEEF);
        rd(4'd8, 32'h0BADF00D);

        // Throughput: 8 back-to-back reads of value=addr
        for (int i = 0; i < 8; i++) wr(4'(i), 32'(i), 4'hF);
        for (int k = 0; k < 8; k++) begin
            re = 1'b1; raddr = 4'(k);
            tick();
            chk("thr_a_valid", {31'd0, a_valid}, 32'd1);
            chk("thr_a_data", a_data, 32'(k));
            chk("thr_b_valid", {31'd0, b_valid}, (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) chk("thr_b_data", b_data, 32'(k - 1));
            $display("stream k %0d a %h/%b b %h/%b", k, a_data, a_valid, b_data, b_valid);
        end
        re = 1'b0;
        tick();
        chk("thr_a_end", {31'd0, a_valid}, 32'd0);
        chk("thr_a_hold", a_data, 32'd7);
        chk("thr_b_last_valid", {31'd0, b_valid}, 32'd1);
        chk("thr_b_last", b_data, 32'd7);
        tick();
        chk("thr_b_end", {31'd0, b_valid}, 32'd0);
        chk("thr_b_hold", b_data, 32'd7);

        // Runtime clear with a second pulse at busy cycle 5
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFFFFFF, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy_rise", {31'd0, a_busy}, 32'd1);
        count_busy("rtclr", 4);
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);

        // Reset in the middle of a clear
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFFFFFF, 4'hF);
        rd(4'd0, 32'hFFFFFFFF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_a_valid", {31'd0, a_valid}, 32'd0);
        chk("mid_a_data", a_data, 32'd0);
        chk("mid_b_valid", {31'd0, b_valid}, 32'd0);
        chk("mid_b_data", b_data, 32'd0);
        $display("reset mid-clear data a %h b %h", a_data, b_data);
        tick(); tick();
        rst_n = 1'b1;
        count_busy("midrst", -1);
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
